// File: rtl/zap_async_event_scheduler.sv
// Async event collector: per-line sync + edge detect, saturating
// pending counters and a round-robin valid/ready issue slot.
module zap_async_event_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 3,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_async,
    input  logic [NUM_REQ-1:0] i_enable,
    input  logic               i_ready,
    input  logic [NUM_REQ-1:0] i_clr_ovf,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_id,
    output logic [NUM_REQ-1:0] o_pending,
    output logic [NUM_REQ-1:0] o_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [ID_W-1:0]  PTR_RST = ID_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] meta_q;
    logic [NUM_REQ-1:0] sync_q;
    logic [NUM_REQ-1:0] prev_q;
    logic [NUM_REQ-1:0] edge_w;

    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0] ovf_d;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] dec;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    win_id;
    logic               win_found;
    logic               load;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign edge_w = sync_q & ~prev_q;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i]      = i_enable[i] && (cnt_q[i] != '0);
            o_pending[i] = (cnt_q[i] != '0);
        end
    end

    // Search starts one past the last winner and wraps around.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign load = (!o_valid || i_ready) && win_found;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            dec[i]   = load && (win_id == ID_W'(i));
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = o_overflow[i] && !i_clr_ovf[i];
            if (!i_enable[i]) begin
                cnt_d[i] = '0;
            end else begin
                unique case (1'b1)
                    (edge_w[i] && !dec[i]): begin
                        if (cnt_q[i] == CNT_MAX)
                            ovf_d[i] = 1'b1;
                        else
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                    (dec[i] && !edge_w[i]): cnt_d[i] = cnt_q[i] - CNT_ONE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REQ; i++)
                cnt_q[i] <= '0;
            o_overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                cnt_q[i] <= cnt_d[i];
            o_overflow <= ovf_d;
        end
    end

    // A held slot keeps its id even if its source is disabled later.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_id    <= '0;
            rr_ptr  <= PTR_RST;
        end else if (load) begin
            o_valid <= 1'b1;
            o_id    <= win_id;
            rr_ptr  <= win_id;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_zap_async_event_scheduler.sv
// Scoreboard bench: expected grant ids queued by stimulus,
// popped by a negedge monitor on every accepted transfer.
module tb_zap_async_event_scheduler;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 3;
    localparam int ID_W    = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_REQ-1:0] async_l;
    logic [NUM_REQ-1:0] enable;
    logic               ready;
    logic [NUM_REQ-1:0] clr_ovf;
    logic               o_valid;
    logic [ID_W-1:0]    o_id;
    logic [NUM_REQ-1:0] o_pending;
    logic [NUM_REQ-1:0] o_overflow;

    int checks = 0;
    int errors = 0;
    logic [ID_W-1:0] exp_q [$];

    zap_async_event_scheduler #(
        .NUM_REQ (NUM_REQ),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_async    (async_l),
        .i_enable   (enable),
        .i_ready    (ready),
        .i_clr_ovf  (clr_ovf),
        .o_valid    (o_valid),
        .o_id       (o_id),
        .o_pending  (o_pending),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && o_valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: got id %0d, required no transfer", o_id);
            end else begin
                logic [ID_W-1:0] e;
                e = exp_q.pop_front();
                if (o_id !== e) begin
                    errors++;
                    $display("FAIL grant_id: got %0d, required %0d", o_id, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic pulse(input logic [NUM_REQ-1:0] m);
        async_l = async_l | m;
        tick();
        tick();
        async_l = async_l & ~m;
        tick();
        tick();
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!o_valid && n < 20) begin
            tick();
            n++;
        end
        chk(nm, int'(o_valid), 1);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk(nm, exp_q.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        async_l = '0;
        enable  = '1;
        ready   = 1'b0;
        clr_ovf = '0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_id", int'(o_id), 0);
        chk("rst_pending", int'(o_pending), 0);
        chk("rst_ovf", int'(o_overflow), 0);

        // 1: single pulse latency
        ready = 1'b1;
        exp_q.push_back(2'd0);
        async_l = 4'b0001;
        tick();
        tick();
        tick();
        async_l = '0;
        chk("t1_valid_e3", int'(o_valid), 0);
        chk("t1_pend_e3", int'(o_pending), 1);
        tick();
        chk("t1_valid_e4", int'(o_valid), 1);
        chk("t1_id_e4", int'(o_id), 0);
        tick();
        chk("t1_valid_e5", int'(o_valid), 0);
        chk("t1_queue", exp_q.size(), 0);

        // 2: all lines at once, back-to-back
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(ID_W'(i));
        async_l = 4'b1111;
        tick();
        tick();
        async_l = '0;
        wait_valid("t2_first_valid");
        for (int k = 0; k < 4; k++) begin
            chk("t2_b2b_valid", int'(o_valid), 1);
            tick();
        end
        chk("t2_idle", int'(o_valid), 0);
        chk("t2_queue", exp_q.size(), 0);

        // 3: saturation and overflow
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(2'd2);
        for (int i = 0; i < 8; i++) pulse(4'b0100);
        chk("t3_valid", int'(o_valid), 1);
        chk("t3_id", int'(o_id), 2);
        chk("t3_pend", int'(o_pending), 4);
        chk("t3_ovf_pre", int'(o_overflow), 0);
        pulse(4'b0100);
        chk("t3_ovf_set", int'(o_overflow), 4);
        clr_ovf = 4'b0100;
        tick();
        clr_ovf = '0;
        chk("t3_ovf_clr", int'(o_overflow), 0);
        ready = 1'b1;
        drain("t3_drain");
        chk("t3_idle", int'(o_valid), 0);
        chk("t3_pend_end", int'(o_pending), 0);

        // 4: disabled source ignores edges
        do_reset();
        ready  = 1'b1;
        enable = 4'b1101;
        pulse(4'b0010);
        pulse(4'b0010);
        tick();
        tick();
        chk("t4_no_valid", int'(o_valid), 0);
        chk("t4_no_pend", int'(o_pending), 0);
        enable = 4'b1111;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        pulse(4'b0010);
        pulse(4'b0010);
        drain("t4_drain");

        // 5: stall holds id, then rotation from rr_ptr+1
        do_reset();
        exp_q.push_back(2'd0);
        pulse(4'b0001);
        wait_valid("t5_valid");
        chk("t5_id", int'(o_id), 0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        pulse(4'b1000);
        chk("t5_hold_a", int'({o_valid, o_id}), 4);
        pulse(4'b0011);
        chk("t5_hold_b", int'({o_valid, o_id}), 4);
        pulse(4'b0100);
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold", int'({o_valid, o_id}), 4);
            tick();
        end
        chk("t5_pend", int'(o_pending), 15);
        ready = 1'b1;
        drain("t5_drain");

        // 6: reset mid-operation discards everything
        do_reset();
        for (int i = 0; i < 4; i++) pulse(4'b0010);
        chk("t6_pend", int'(o_pending), 2);
        chk("t6_valid", int'(o_valid), 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", int'(o_valid), 0);
        chk("t6_rst_id", int'(o_id), 0);
        chk("t6_rst_pend", int'(o_pending), 0);
        tick();
        rst   = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("t6_quiet", int'(o_valid), 0);
        rst     = 1'b1;
        async_l = 4'b1000;
        tick();
        rst = 1'b0;
        exp_q.push_back(2'd3);
        drain("t6_held_line");
        for (int k = 0; k < 6; k++) tick();
        async_l = '0;
        for (int k = 0; k < 6; k++) tick();
        chk("t6_end_idle", int'(o_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
